// File: rtl/alt_ddrx_ddr2_odt_chk_if.sv
// alt_ddrx_ddr2_odt_chk_if
//   Bundles the command strobes, expected delays, per-phase ODT stream and
//   the checker's status outputs of alt_ddrx_ddr2_odt_chk.
//   master : the controller side / bench (drives commands and ODT stream)
//   slave  : the ODT checker (samples the stream, drives status)
// Signals:
//   do_write, do_read       command strobes
//   exp_wr_dly, exp_rd_dly  expected command-to-ODT-rise delay, in phases
//   int_odt_l, int_odt_h    ODT level, phase 0 / phase 1
//   err_*                   one-cycle error pulses, err_sticky is cumulative
//   ok_cnt, err_cnt         saturating match / error-cycle counters
//   q_level                 pending-command queue occupancy
interface alt_ddrx_ddr2_odt_chk_if #(
  parameter int DLY_WIDTH = 6
);
  logic                 do_write;
  logic                 do_read;
  logic [DLY_WIDTH-1:0] exp_wr_dly;
  logic [DLY_WIDTH-1:0] exp_rd_dly;
  logic                 int_odt_l;
  logic                 int_odt_h;
  logic                 err_missing;
  logic                 err_spurious;
  logic                 err_short;
  logic                 err_long;
  logic                 err_overflow;
  logic                 err_sticky;
  logic [15:0]          ok_cnt;
  logic [7:0]           err_cnt;
  logic [2:0]           q_level;

  modport master (
    output do_write, do_read, exp_wr_dly, exp_rd_dly, int_odt_l, int_odt_h,
    input  err_missing, err_spurious, err_short, err_long, err_overflow,
    input  err_sticky, ok_cnt, err_cnt, q_level
  );

  modport slave (
    input  do_write, do_read, exp_wr_dly, exp_rd_dly, int_odt_l, int_odt_h,
    output err_missing, err_spurious, err_short, err_long, err_overflow,
    output err_sticky, ok_cnt, err_cnt, q_level
  );
endinterface

// File: rtl/alt_ddrx_ddr2_odt_chk.sv
// alt_ddrx_ddr2_odt_chk
//   DDR2 ODT compliance checker. Every write/read command queues the
//   timestamp at which ODT is expected to rise; the per-phase ODT stream is
//   decoded back into windows and each rise, fall and run length is checked
//   against the queued expectations.
// Ports:
//   ctl_clk      controller clock
//   ctl_reset_n  asynchronous active-low reset
//   bus          alt_ddrx_ddr2_odt_chk_if.slave (commands, ODT stream, status)
// Configuration:
//   ALT_DDRX_ODT_CHK_LONG_EN  when defined, the over-long window check is
//                             built in; otherwise err_long is tied low.
module alt_ddrx_ddr2_odt_chk #(
  parameter int DWIDTH_RATIO = 2,
  parameter int ODT_LEN      = 4,
  parameter int ODT_SLACK    = 2,
  parameter int DLY_WIDTH    = 6
) (
  input logic                    ctl_clk,
  input logic                    ctl_reset_n,
  alt_ddrx_ddr2_odt_chk_if.slave bus
);

  localparam int         PH       = (DWIDTH_RATIO == 4) ? 2 : 1;
  localparam logic [7:0] PH_TS    = 8'(PH);
  localparam logic [7:0] LEN_M1   = 8'(ODT_LEN - 1);
  localparam logic [7:0] SLACK_P1 = 8'(ODT_SLACK + 1);

  // Delay is clamped to at least one cycle of phases so a push is always
  // in the queue before its rise timestamp is evaluated.
  function automatic logic [7:0] clamp_dly(input logic [DLY_WIDTH-1:0] dly);
    logic [7:0] d;
    d = 8'(dly);
    return (d < PH_TS) ? PH_TS : d;
  endfunction

  logic [7:0]  ts_r;
  logic [7:0]  q_mem_r [0:3];
  logic [1:0]  rd_ptr_r;
  logic [1:0]  wr_ptr_r;
  logic [2:0]  count_r;
  logic        prev_odt_r;
  logic        hold_valid_r;
  logic [7:0]  hold_r;

  logic        err_missing_r;
  logic        err_spurious_r;
  logic        err_short_r;
  logic        err_overflow_r;
  logic        err_sticky_r;
  logic [15:0] ok_cnt_r;
  logic [7:0]  err_cnt_r;

  logic [1:0]  odt_ph_s;
  logic        lvl_s;
  logic        hv_s;
  logic [7:0]  hold_s;
  logic [7:0]  t_s;
  logic [7:0]  diff_s;
  logic        odt_s;
  logic        hit_s;
  logic        match_s;
  logic        fall_s;
  logic        long_hit_s;
  logic [1:0]  n_pop_s;
  logic [1:0]  n_match_s;
  logic        miss_s;
  logic        spur_s;
  logic        short_s;
  logic        any_err_s;
  logic        cmd_s;
  logic        conflict_s;
  logic [2:0]  cnt_after_pop_s;
  logic        push_s;
  logic        ovf_s;
  logic [7:0]  push_val_s;
  logic [16:0] ok_sum_s;
`ifdef ALT_DDRX_ODT_CHK_LONG_EN
  logic        long_s;
  logic        ls_s;
  logic        long_seen_r;
  logic        err_long_r;
`endif

  // Walk the phases of this cycle in order, tracking level, hold window and queue pops.
  always_comb begin
    odt_ph_s   = {((PH == 2) ? bus.int_odt_h : 1'b0), bus.int_odt_l};
    lvl_s      = prev_odt_r;
    hv_s       = hold_valid_r;
    hold_s     = hold_r;
    t_s        = ts_r;
    diff_s     = 8'd0;
    odt_s      = 1'b0;
    hit_s      = 1'b0;
    match_s    = 1'b0;
    fall_s     = 1'b0;
    long_hit_s = 1'b0;
    n_pop_s    = 2'd0;
    n_match_s  = 2'd0;
    miss_s     = 1'b0;
    spur_s     = 1'b0;
    short_s    = 1'b0;
`ifdef ALT_DDRX_ODT_CHK_LONG_EN
    long_s     = 1'b0;
    ls_s       = long_seen_r;
`endif
    for (int k = 0; k < PH; k++) begin
      t_s        = ts_r + 8'(k);
      odt_s      = odt_ph_s[k];
      // Only the current head can match; entries popped earlier this cycle are skipped.
      hit_s      = (count_r > {1'b0, n_pop_s}) && (q_mem_r[rd_ptr_r + n_pop_s] == t_s);
      match_s    = hit_s & odt_s;
      n_pop_s    = n_pop_s + {1'b0, hit_s};
      n_match_s  = n_match_s + {1'b0, match_s};
      miss_s     = miss_s | (hit_s & ~odt_s);
      spur_s     = spur_s | (odt_s & ~lvl_s & ~hit_s);
      // A match (also while already high) restarts the minimum-length window.
      hold_s     = match_s ? (t_s + LEN_M1) : hold_s;
      hv_s       = hv_s | match_s;
      // Signed mod-256 distance: bit 7 clear means t is at or before hold_until.
      diff_s     = hold_s - t_s;
      fall_s     = lvl_s & ~odt_s;
      short_s    = short_s | (fall_s & hv_s & ~diff_s[7]);
      long_hit_s = odt_s & hv_s & (t_s == (hold_s + SLACK_P1));
      // The window retires on fall or once the slack is exhausted, so it
      // never aliases against a wrapped timestamp.
      hv_s       = hv_s & ~fall_s & ~long_hit_s;
`ifdef ALT_DDRX_ODT_CHK_LONG_EN
      long_s     = long_s | (long_hit_s & ~ls_s);
      ls_s       = (ls_s | long_hit_s) & odt_s;
`endif
      lvl_s      = odt_s;
    end
  end

  // Command decode and queue push decision; space freed by this cycle's pops is reusable.
  always_comb begin
    cmd_s           = bus.do_write ^ bus.do_read;
    conflict_s      = bus.do_write & bus.do_read;
    cnt_after_pop_s = count_r - {1'b0, n_pop_s};
    push_s          = cmd_s & ~cnt_after_pop_s[2];
    ovf_s           = conflict_s | (cmd_s & cnt_after_pop_s[2]);
    push_val_s      = ts_r + clamp_dly(bus.do_write ? bus.exp_wr_dly : bus.exp_rd_dly);
    ok_sum_s        = {1'b0, ok_cnt_r} + {15'd0, n_match_s};
`ifdef ALT_DDRX_ODT_CHK_LONG_EN
    any_err_s       = miss_s | spur_s | short_s | long_s | ovf_s;
`else
    any_err_s       = miss_s | spur_s | short_s | ovf_s;
`endif
  end

  // Timestamp, command queue and run-tracking state.
  always_ff @(posedge ctl_clk or negedge ctl_reset_n) begin
    if (!ctl_reset_n) begin
      ts_r         <= 8'd0;
      rd_ptr_r     <= 2'd0;
      wr_ptr_r     <= 2'd0;
      count_r      <= 3'd0;
      prev_odt_r   <= 1'b0;
      hold_valid_r <= 1'b0;
      hold_r       <= 8'd0;
      for (int i = 0; i < 4; i++) begin
        q_mem_r[i] <= 8'd0;
      end
`ifdef ALT_DDRX_ODT_CHK_LONG_EN
      long_seen_r  <= 1'b0;
`endif
    end else begin
      ts_r         <= ts_r + PH_TS;
      rd_ptr_r     <= rd_ptr_r + n_pop_s;
      count_r      <= cnt_after_pop_s + {2'b00, push_s};
      prev_odt_r   <= lvl_s;
      hold_valid_r <= hv_s;
      hold_r       <= hold_s;
      if (push_s) begin
        q_mem_r[wr_ptr_r] <= push_val_s;
        wr_ptr_r          <= wr_ptr_r + 2'd1;
      end
`ifdef ALT_DDRX_ODT_CHK_LONG_EN
      long_seen_r  <= ls_s;
`endif
    end
  end

  // Registered error pulses and saturating counters.
  always_ff @(posedge ctl_clk or negedge ctl_reset_n) begin
    if (!ctl_reset_n) begin
      err_missing_r  <= 1'b0;
      err_spurious_r <= 1'b0;
      err_short_r    <= 1'b0;
      err_overflow_r <= 1'b0;
      err_sticky_r   <= 1'b0;
      ok_cnt_r       <= 16'd0;
      err_cnt_r      <= 8'd0;
`ifdef ALT_DDRX_ODT_CHK_LONG_EN
      err_long_r     <= 1'b0;
`endif
    end else begin
      err_missing_r  <= miss_s;
      err_spurious_r <= spur_s;
      err_short_r    <= short_s;
      err_overflow_r <= ovf_s;
      err_sticky_r   <= err_sticky_r | any_err_s;
      ok_cnt_r       <= ok_sum_s[16] ? 16'hFFFF : ok_sum_s[15:0];
      err_cnt_r      <= (any_err_s && (err_cnt_r != 8'hFF)) ? (err_cnt_r + 8'd1) : err_cnt_r;
`ifdef ALT_DDRX_ODT_CHK_LONG_EN
      err_long_r     <= long_s;
`endif
    end
  end

  assign bus.err_missing  = err_missing_r;
  assign bus.err_spurious = err_spurious_r;
  assign bus.err_short    = err_short_r;
  assign bus.err_overflow = err_overflow_r;
  assign bus.err_sticky   = err_sticky_r;
  assign bus.ok_cnt       = ok_cnt_r;
  assign bus.err_cnt      = err_cnt_r;
  assign bus.q_level      = count_r;
`ifdef ALT_DDRX_ODT_CHK_LONG_EN
  assign bus.err_long     = err_long_r;
`else
  assign bus.err_long     = 1'b0;
`endif

endmodule

// File: tb/tb_alt_ddrx_ddr2_odt_chk.sv
// Bench for alt_ddrx_ddr2_odt_chk: one full-rate and one half-rate instance.
// Expected events are queued per scenario and checked cycle by cycle.
module tb_alt_ddrx_ddr2_odt_chk;

  localparam logic [5:0] EV_OK    = 6'b000001;
  localparam logic [5:0] EV_MISS  = 6'b000010;
  localparam logic [5:0] EV_SPUR  = 6'b000100;
  localparam logic [5:0] EV_SHORT = 6'b001000;
  localparam logic [5:0] EV_LONG  = 6'b010000;
  localparam logic [5:0] EV_OVF   = 6'b100000;

  typedef struct {
    int         cyc;
    logic [5:0] ev;
    int         ql;
  } ev_t;

  logic ctl_clk = 1'b0;
  logic ctl_reset_n;
  always #5 ctl_clk = ~ctl_clk;

  alt_ddrx_ddr2_odt_chk_if #(.DLY_WIDTH(6)) bus_fr ();
  alt_ddrx_ddr2_odt_chk_if #(.DLY_WIDTH(6)) bus_hr ();

  alt_ddrx_ddr2_odt_chk #(.DWIDTH_RATIO(2), .ODT_LEN(4), .ODT_SLACK(2), .DLY_WIDTH(6)) u_dut_fr (
    .ctl_clk     (ctl_clk),
    .ctl_reset_n (ctl_reset_n),
    .bus         (bus_fr)
  );

  alt_ddrx_ddr2_odt_chk #(.DWIDTH_RATIO(4), .ODT_LEN(4), .ODT_SLACK(2), .DLY_WIDTH(6)) u_dut_hr (
    .ctl_clk     (ctl_clk),
    .ctl_reset_n (ctl_reset_n),
    .bus         (bus_hr)
  );

  int  n_vec = 0;
  int  n_err = 0;
  ev_t sbq[$];
  bit  wr_c   [0:511];
  bit  rd_c   [0:511];
  bit  odt_ts [0:1023];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic clr_stim();
    for (int i = 0; i < 512; i++) begin
      wr_c[i] = 1'b0;
      rd_c[i] = 1'b0;
    end
    for (int i = 0; i < 1024; i++) odt_ts[i] = 1'b0;
  endtask

  task automatic set_odt(input int a, input int b);
    for (int i = a; i <= b; i++) odt_ts[i] = 1'b1;
  endtask

  task automatic push_ev(input int cyc, input logic [5:0] ev, input int ql);
    ev_t e;
    e.cyc = cyc;
    e.ev  = ev;
    e.ql  = ql;
    sbq.push_back(e);
  endtask

  task automatic drive(input bit half, input int n);
    if (!half) begin
      bus_fr.do_write  = wr_c[n];
      bus_fr.do_read   = rd_c[n];
      bus_fr.int_odt_l = odt_ts[n];
      bus_fr.int_odt_h = 1'($urandom_range(0, 1));
    end else begin
      bus_hr.do_write  = wr_c[n];
      bus_hr.do_read   = rd_c[n];
      bus_hr.int_odt_l = odt_ts[2*n];
      bus_hr.int_odt_h = odt_ts[2*n+1];
    end
  endtask

  task automatic sample(input bit half, output logic [4:0] p, output logic [15:0] okc,
                        output logic [7:0] ec, output logic st, output logic [2:0] ql);
    if (!half) begin
      p   = {bus_fr.err_overflow, bus_fr.err_long, bus_fr.err_short, bus_fr.err_spurious, bus_fr.err_missing};
      okc = bus_fr.ok_cnt;
      ec  = bus_fr.err_cnt;
      st  = bus_fr.err_sticky;
      ql  = bus_fr.q_level;
    end else begin
      p   = {bus_hr.err_overflow, bus_hr.err_long, bus_hr.err_short, bus_hr.err_spurious, bus_hr.err_missing};
      okc = bus_hr.ok_cnt;
      ec  = bus_hr.err_cnt;
      st  = bus_hr.err_sticky;
      ql  = bus_hr.q_level;
    end
  endtask

  task automatic run_scn(input bit half, input int ncyc, input logic [5:0] wd, input logic [5:0] rdl);
    logic [4:0]  p;
    logic [15:0] okc;
    logic [7:0]  ec;
    logic        st;
    logic [2:0]  ql;
    logic [5:0]  e;
    int          nok;
    int          qlx;
    int          ok_e;
    int          ec_e;
    logic        st_e;
    ctl_reset_n = 1'b0;
    bus_fr.do_write = 1'b0; bus_fr.do_read = 1'b0; bus_fr.int_odt_l = 1'b0; bus_fr.int_odt_h = 1'b0;
    bus_hr.do_write = 1'b0; bus_hr.do_read = 1'b0; bus_hr.int_odt_l = 1'b0; bus_hr.int_odt_h = 1'b0;
    bus_fr.exp_wr_dly = wd; bus_fr.exp_rd_dly = rdl;
    bus_hr.exp_wr_dly = wd; bus_hr.exp_rd_dly = rdl;
    repeat (2) @(posedge ctl_clk);
    #1;
    sample(half, p, okc, ec, st, ql);
    chk("rst_pulses", {27'd0, p}, 32'd0);
    chk("rst_counts", {okc, ec, 5'd0, ql}, 32'd0);
    chk("rst_sticky", {31'd0, st}, 32'd0);
    @(negedge ctl_clk);
    ctl_reset_n = 1'b1;
    ok_e = 0;
    ec_e = 0;
    st_e = 1'b0;
    for (int n = 0; n < ncyc; n++) begin
      drive(half, n);
      @(posedge ctl_clk);
      #1;
      sample(half, p, okc, ec, st, ql);
      e   = 6'd0;
      nok = 0;
      qlx = -1;
      for (int i = sbq.size() - 1; i >= 0; i--) begin
        if (sbq[i].cyc == n + 1) begin
          e = e | sbq[i].ev;
          if (sbq[i].ev[0]) nok++;
          if (sbq[i].ql >= 0) qlx = sbq[i].ql;
          sbq.delete(i);
        end
      end
      ok_e = (ok_e + nok > 65535) ? 65535 : ok_e + nok;
      if (e[5:1] != 5'd0) begin
        ec_e = (ec_e == 255) ? 255 : ec_e + 1;
        st_e = 1'b1;
      end
      chk("pulses",  {27'd0, p},  {27'd0, e[5:1]});
      chk("ok_cnt",  {16'd0, okc}, 32'(ok_e));
      chk("err_cnt", {24'd0, ec},  32'(ec_e));
      chk("sticky",  {31'd0, st},  {31'd0, st_e});
      if (qlx >= 0) chk("q_level", {29'd0, ql}, 32'(qlx));
      @(negedge ctl_clk);
    end
    chk("sb_left", 32'(sbq.size()), 32'd0);
    sbq.delete();
  endtask

  initial begin
    ctl_reset_n = 1'b0;
    // Nominal, full rate
    clr_stim(); wr_c[10] = 1'b1; set_odt(13, 16);
    push_ev(11, 6'd0, 1); push_ev(14, EV_OK, 0);
    run_scn(1'b0, 30, 6'd3, 6'd7);
    // Short window
    clr_stim(); wr_c[10] = 1'b1; set_odt(13, 15);
    push_ev(14, EV_OK, 0); push_ev(17, EV_SHORT, -1);
    run_scn(1'b0, 30, 6'd3, 6'd7);
    // Missing, then spurious
    clr_stim(); rd_c[10] = 1'b1; set_odt(40, 40);
    push_ev(11, 6'd0, 1); push_ev(14, EV_MISS, 0); push_ev(41, EV_SPUR, -1);
    run_scn(1'b0, 50, 6'd9, 6'd3);
    // Half rate nominal: rise on the h phase
    clr_stim(); rd_c[5] = 1'b1; set_odt(15, 19);
    push_ev(6, 6'd0, 1); push_ev(8, EV_OK, 0);
    run_scn(1'b1, 20, 6'd9, 6'd5);
    // Half rate, delay below one cycle is clamped to 2 phases
    clr_stim(); wr_c[5] = 1'b1; set_odt(12, 15);
    push_ev(6, 6'd0, 1); push_ev(7, EV_OK, 0);
    run_scn(1'b1, 20, 6'd1, 6'd9);
    // Half rate, two matches in one cycle (second while already high)
    clr_stim(); rd_c[5] = 1'b1; wr_c[6] = 1'b1; set_odt(14, 20);
    push_ev(7, 6'd0, 2); push_ev(8, EV_OK, 0); push_ev(8, EV_OK, -1);
    run_scn(1'b1, 20, 6'd3, 6'd4);
    // Queue full and simultaneous strobes; queued commands later miss
    clr_stim();
    for (int i = 10; i <= 14; i++) wr_c[i] = 1'b1;
    wr_c[15] = 1'b1; rd_c[15] = 1'b1;
    push_ev(14, 6'd0, 4); push_ev(15, EV_OVF, 4); push_ev(16, EV_OVF, 4);
    push_ev(51, EV_MISS, -1); push_ev(52, EV_MISS, -1); push_ev(53, EV_MISS, -1); push_ev(54, EV_MISS, 0);
    run_scn(1'b0, 60, 6'd40, 6'd3);
    // Long window
    clr_stim(); wr_c[10] = 1'b1; set_odt(13, 20);
    push_ev(14, EV_OK, 0);
`ifdef ALT_DDRX_ODT_CHK_LONG_EN
    push_ev(20, EV_LONG, -1);
`endif
    run_scn(1'b0, 30, 6'd3, 6'd3);
    // err_cnt saturation: conflicting strobes every cycle
    clr_stim();
    for (int i = 0; i < 300; i++) begin
      wr_c[i] = 1'b1;
      rd_c[i] = 1'b1;
      push_ev(i + 1, EV_OVF, 0);
    end
    run_scn(1'b0, 302, 6'd3, 6'd3);
    // Reset while a command is pending; nothing must be reported afterwards
    clr_stim(); wr_c[10] = 1'b1;
    push_ev(11, 6'd0, 1);
    run_scn(1'b0, 15, 6'd20, 6'd3);
    clr_stim();
    push_ev(20, 6'd0, 0);
    run_scn(1'b0, 50, 6'd20, 6'd3);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/alt_ddrx_ddr2_odt_chk.md
# alt_ddrx_ddr2_odt_chk

On-chip DDR2 ODT compliance checker for the controller's write/read ODT path. It receives the per-phase ODT stream (`int_odt_l`/`int_odt_h`) and the `do_write`/`do_read` command strobes that produced it. It decodes the stream back into ODT windows and confirms that each window rises at the expected memory-clock phase after its command and lasts the required length. Violations are reported as pulses, a sticky flag and saturating counters, for debug and for bring-up benches.

## Interface
Parameters:
- `DWIDTH_RATIO`, 2. Value 2 is full rate: PH=1 phase per `ctl_clk`, only `int_odt_l` is used. Value 4 is half rate: PH=2, `int_odt_l` is phase 0 and `int_odt_h` is phase 1.
- `ODT_LEN`, 4. Minimum ODT window length, in memory-clock phases.
- `ODT_SLACK`, 2. Extra phases allowed beyond `ODT_LEN` before a window counts as long.
- `DLY_WIDTH`, 6. Width of the expected-delay inputs.

Ports:
- `ctl_clk`, in, 1. Controller clock.
- `ctl_reset_n`, in, 1. Reset: asynchronous, active-low.
- `do_write`, in, 1. Write command issued this cycle.
- `do_read`, in, 1. Read command issued this cycle.
- `exp_wr_dly`, in, DLY_WIDTH. Expected phases from a write command to ODT rise; quasi-static.
- `exp_rd_dly`, in, DLY_WIDTH. Expected phases from a read command to ODT rise; quasi-static.
- `int_odt_l`, in, 1. ODT, phase 0.
- `int_odt_h`, in, 1. ODT, phase 1. Ignored at full rate.
- `err_missing`, out, 1. Pulse: ODT was low at an expected rise phase.
- `err_spurious`, out, 1. Pulse: ODT rose with no matching command.
- `err_short`, out, 1. Pulse: window fell before `ODT_LEN` elapsed.
- `err_long`, out, 1. Pulse: window exceeded its hold plus `ODT_SLACK`.
- `err_overflow`, out, 1. Pulse: command dropped because the queue was full, or both strobes were asserted in the same cycle.
- `err_sticky`, out, 1. OR of all error pulses since reset.
- `ok_cnt`, out, 16. Matched windows, saturating.
- `err_cnt`, out, 8. Error cycles, saturating.
- `q_level`, out, 3. Pending-command queue occupancy, 0..4.

## Operation
**Timestamp**
- Free-running 8-bit counter `ts`, modulo 256. Increments by PH each cycle.
- Phase k of a cycle has timestamp `ts+k`.

**Command queue**
- 4-entry FIFO of expected rise timestamps.
- A command sampled in cycle n pushes `ts(n) + max(exp_dly, PH)`, taking `exp_wr_dly` or `exp_rd_dly` by command type.
- `do_write` and `do_read` asserted together: nothing is pushed; `err_overflow` fires.
- Push when the queue is full: the command is dropped; `err_overflow` fires.

**Phase evaluation**
Phases are evaluated in order 0..PH-1. At each phase t:
- If the queue head equals t:
  - ODT=1: match. Pop the head, increment `ok_cnt`, set `hold_until = t+ODT_LEN-1`.
  - ODT=0: `err_missing`. Pop the head.
- Up to PH pops per cycle are allowed.
- A 0→1 ODT transition at t with no head match at t: `err_spurious`.
- A 1→0 transition at t with t ≤ `hold_until` (modulo-256 window compare, active run only): `err_short`.
- ODT still high at `hold_until + ODT_SLACK + 1`: `err_long`, reported once per run.
- A match while ODT is already high (back-to-back commands) is legal; it extends `hold_until`.

**Phase-to-phase state**
- The previous ODT level carries across phases and across cycles.
- Reset value of the previous level is 0.

**Error accounting**
- `err_cnt` increments by 1 in any cycle where any error pulse is asserted.

## Timing
- All outputs are registered.
- An error pulse or `ok_cnt` update appears in cycle n+1 for a phase evaluated in cycle n.
- Reset values: all outputs 0; `ts`=0; queue empty; previous level 0; `hold_until` inactive.
- Reset asserted mid-operation clears all state immediately. Pending commands are lost and no errors are reported for them.
- A push in cycle n is visible for matching from cycle n+1. Clamping the delay to at least PH guarantees this.
- A pop and a push in the same cycle are both honoured. `q_level` reflects the net change.
- Counters hold at their maximum value (`ok_cnt` 16'hFFFF, `err_cnt` 8'hFF).

## Configuration
- `ALT_DDRX_ODT_CHK_LONG_EN` defined: the `err_long` check and its run-extension tracking are compiled in.
- `ALT_DDRX_ODT_CHK_LONG_EN` not defined: `err_long` is tied to 0 and never contributes to `err_sticky` or `err_cnt`. All other behaviour is unchanged.

## Test plan
- Nominal, full rate:
  - Stimulus: `exp_wr_dly`=3; `do_write` at cycle 10 (ts=10); `int_odt_l` high cycles 13–16.
  - Response: `ok_cnt`=1 from cycle 14; no errors.
- Short window:
  - Stimulus: as nominal, but `int_odt_l` high cycles 13–15 only.
  - Response: `err_short` pulse at cycle 17; `err_sticky`=1; `err_cnt`=1.
- Missing, then spurious:
  - Stimulus: `do_read` at cycle 10, `exp_rd_dly`=3, ODT stays low; later an ODT pulse at cycle 40 with no command.
  - Response: `err_missing` at cycle 14; `err_spurious` at cycle 41.
- Half rate:
  - Stimulus: `DWIDTH_RATIO`=4; `do_read` at cycle 5 (ts=10); `exp_rd_dly`=5 (expected phase 15, the h phase of cycle 7); `int_odt_h` high at cycle 7; both phases high at cycles 8–9.
  - Response: match; `ok_cnt`=1 at cycle 8; no errors.
- Overflow and conflict:
  - Stimulus: `exp_wr_dly`=40; 5 consecutive `do_write`; then `do_write` and `do_read` together.
  - Response: `q_level`=4; `err_overflow` on the 5th command and on the simultaneous command.
- Long window (macro defined):
  - Stimulus: nominal command, but ODT held high cycles 13–20.
  - Response: a single `err_long` pulse at cycle 20.
